rf_operand_fetch: RTL and testbench

//  Operand-fetch/issue stage that drives the read side of the 8x64 register file.
//  - Accepts decoded instructions on a valid/ready input and issues rs0/rs1 to RF read ports.
//  - Captures both operands and presents them to execute on a registered valid/ready output.
//  - Keeps a pending-write scoreboard, stalling RAW/WAW hazards until writeback retires them.

---
 rtl/rf_operand_fetch.sv | 198 +++++++++++++++++++
 tb/tb_rf_operand_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: operand-fetch/issue stage in front of an 8x64 register file.
// Accepts decoded instructions and reads both source registers from the RF.
// Holds one issued instruction in a registered output slot toward execute.
// Tracks pending destination writes and stalls RAW/WAW hazards until writeback.
// Optional feature macro: RF_BYPASS_EN.
// - Defined: a same-cycle writeback clears the hazard, and its data is forwarded.
// - Undefined: the consumer waits until the cycle after writeback and reads the RF.
module rf_operand_fetch #(
  parameter int unsigned DW   = 64,
  parameter int unsigned AW   = 3,
  parameter int unsigned OPW  = 8,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // decoded instruction input
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [AW-1:0]   in_rs0,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_wen,
  // register file read ports
  output logic [AW-1:0]   rf_r0addr,
  output logic [AW-1:0]   rf_r1addr,
  input  logic [DW-1:0]   rf_r0data,
  input  logic [DW-1:0]   rf_r1data,
  // writeback (also drives the RF write enable)
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  // issue toward execute
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [DW-1:0]   out_a,
  output logic [DW-1:0]   out_b,
  output logic [AW-1:0]   out_rd,
  output logic            out_wen,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned NREG = 1 << AW;

`ifdef RF_BYPASS_EN
  localparam logic CLR_OK = 1'b1;
`else
  localparam logic CLR_OK = 1'b0;
`endif

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic [OPW-1:0]    r_op;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [AW-1:0]     r_rd;
  logic              r_wen;
  logic [NREG-1:0]   r_pending;
  logic [CNTW-1:0]   r_stall_cnt;

  logic [NREG-1:0]   w_wb_hit;
  logic [NREG-1:0]   w_eff_pend;
  logic [NREG-1:0]   w_pend_nxt;
  logic              w_hazard;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_stall_inc;
  logic [DW-1:0]     w_opnd_a;
  logic [DW-1:0]     w_opnd_b;

  // RF read addresses follow the incoming sources directly
  assign rf_r0addr = in_rs0;
  assign rf_r1addr = in_rs1;

  // One-hot decode of the writeback target
  always_comb begin
    w_wb_hit = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_wb_hit[i] = wb_valid && (wb_addr == AW'(i));
    end
  end

  // Pending bits as seen by hazard detection; a same-cycle writeback only
  // hides its register when forwarding is available
  assign w_eff_pend = r_pending & ~(w_wb_hit & {NREG{CLR_OK}});

  assign w_hazard = w_eff_pend[in_rs0]
                  | w_eff_pend[in_rs1]
                  | (in_wen & w_eff_pend[in_rd]);

  // Output slot can take new data when empty or being drained this cycle
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_slot_free && !w_hazard;
  assign w_accept    = in_valid && in_ready;
  assign w_stall_inc = in_valid && w_hazard;

`ifdef RF_BYPASS_EN
  // Forward writeback data over the RF value it is about to replace
  assign w_opnd_a = (wb_valid && (wb_addr == in_rs0)) ? wb_data : rf_r0data;
  assign w_opnd_b = (wb_valid && (wb_addr == in_rs1)) ? wb_data : rf_r1data;
`else
  logic w_unused_wb_data;

  assign w_opnd_a         = rf_r0data;
  assign w_opnd_b         = rf_r1data;
  // Writeback data only reaches operands through the RF in this build
  assign w_unused_wb_data = ^wb_data;
`endif

  // Issue-slot FSM with registered operand/control payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_wen       <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_op        <= in_op;
            r_a         <= w_opnd_a;
            r_b         <= w_opnd_b;
            r_rd        <= in_rd;
            r_wen       <= in_wen;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_op        <= in_op;
            r_a         <= w_opnd_a;
            r_b         <= w_opnd_b;
            r_rd        <= in_rd;
            r_wen       <= in_wen;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard next state: writeback clears first, a new claim then wins
  always_comb begin
    w_pend_nxt = r_pending;
    if (wb_valid) begin
      w_pend_nxt[wb_addr] = 1'b0;
    end
    if (w_accept && in_wen) begin
      w_pend_nxt[in_rd] = 1'b1;
    end
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  // Saturating count of cycles an offered instruction is held by a hazard
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_op    = r_op;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_rd    = r_rd;
  assign out_wen   = r_wen;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Testbench for rf_operand_fetch: directed scenarios plus randomized traffic
// checked against a transaction-level model of the issue slot and scoreboard.
module tb_rf_operand_fetch;

  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 3;
  localparam int unsigned OPW  = 8;
  localparam int unsigned CNTW = 32;
  localparam int unsigned NREG = 8;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_op;
  logic [AW-1:0]   in_rs0;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rd;
  logic            in_wen;
  logic [AW-1:0]   rf_r0addr;
  logic [AW-1:0]   rf_r1addr;
  logic [DW-1:0]   rf_r0data;
  logic [DW-1:0]   rf_r1data;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  out_op;
  logic [DW-1:0]   out_a;
  logic [DW-1:0]   out_b;
  logic [AW-1:0]   out_rd;
  logic            out_wen;
  logic [CNTW-1:0] stall_cnt;

  rf_operand_fetch #(.DW(DW), .AW(AW), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_wen(in_wen),
    .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr),
    .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, written by writeback at the clock edge
  logic [DW-1:0] rf_mem [NREG];
  assign rf_r0data = rf_mem[rf_r0addr];
  assign rf_r1data = rf_mem[rf_r1addr];
  always @(posedge clk) if (wb_valid) rf_mem[wb_addr] <= wb_data;

  // Reference model state
  bit              m_valid;
  logic [OPW-1:0]  m_op;
  logic [DW-1:0]   m_a;
  logic [DW-1:0]   m_b;
  logic [AW-1:0]   m_rd;
  bit              m_wen;
  bit              m_pend [NREG];
  logic [CNTW-1:0] m_stall;
  bit              exp_ready;
  bit              obs_ready;
  int              n_cmp;
  int              n_bad;

  // A source is blocked while its write is outstanding, unless forwarding
  // can satisfy it from this cycle's writeback
  function automatic bit blocked(input logic [AW-1:0] r, input bit wbv, input logic [AW-1:0] wba);
    return m_pend[r] && !(BYPASS && wbv && (wba == r));
  endfunction

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] r, input bit wbv,
                                            input logic [AW-1:0] wba, input logic [DW-1:0] wbd);
    return (BYPASS && wbv && (wba == r)) ? wbd : rf_mem[r];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
    m_stall = '0;
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // One clock of stimulus; records observed/expected in_ready and advances the model
  task automatic drive_cycle(input bit v, input logic [OPW-1:0] op, input logic [AW-1:0] rs0,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rd, input bit wen,
                             input bit ordy, input bit wbv, input logic [AW-1:0] wba,
                             input logic [DW-1:0] wbd);
    bit haz, acc;
    logic [DW-1:0] a, b;
    @(negedge clk);
    in_valid = v; in_op = op; in_rs0 = rs0; in_rs1 = rs1; in_rd = rd; in_wen = wen;
    out_ready = ordy; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    #1;
    obs_ready = in_ready;
    haz = blocked(rs0, wbv, wba) || blocked(rs1, wbv, wba) || (wen && blocked(rd, wbv, wba));
    exp_ready = (!m_valid || ordy) && !haz;
    acc = v && exp_ready;
    a = operand(rs0, wbv, wba, wbd);
    b = operand(rs1, wbv, wba, wbd);
    @(posedge clk);
    if (v && haz && (m_stall != '1)) m_stall = m_stall + 1;
    if (acc) begin
      m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_rd = rd; m_wen = wen;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (wbv) m_pend[wba] = 1'b0;
    if (acc && wen) m_pend[rd] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_cmp++; if (out_a !== '0 || out_b !== '0) begin n_bad++; $display("FAIL reset_operands got %h/%h want 0/0", out_a, out_b); end
    n_cmp++; if (out_op !== '0 || out_rd !== '0 || out_wen !== 1'b0) begin n_bad++;
      $display("FAIL reset_ctrl got op=%h rd=%0d wen=%0b want 0", out_op, out_rd, out_wen); end
    // Load the RF through writebacks to idle registers (no scoreboard effect)
    for (int i = 0; i < NREG; i++) begin
      logic [DW-1:0] val;
      val = (i == 1) ? 64'd5 : (i == 2) ? 64'd7 : 64'h1000 + 64'(i);
      drive_cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1, AW'(i), val);
    end
    drive_cycle(1'b1, 8'h0F, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", obs_ready); end
    n_cmp++; if (out_a !== 64'h1000) begin n_bad++; $display("FAIL reset_first_issue got %h want 1000", out_a); end
  endtask

  task automatic test_issue();
    drive_cycle(1'b1, 8'hA1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready got %0b want 1", obs_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL issue_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_a !== 64'd5 || out_b !== 64'd7) begin n_bad++; $display("FAIL issue_operands got %0d/%0d want 5/7", out_a, out_b); end
    n_cmp++; if (out_rd !== 3'd3 || out_wen !== 1'b1 || out_op !== 8'hA1) begin n_bad++;
      $display("FAIL issue_ctrl got rd=%0d wen=%0b op=%h want 3/1/a1", out_rd, out_wen, out_op); end
  endtask

  task automatic test_raw_stall();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 8'hB2, 3'd3, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, '0, '0);
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall_ready cyc%0d got %0b want 0", i, obs_ready); end
    end
    n_cmp++; if (stall_cnt !== 32'd2) begin n_bad++; $display("FAIL raw_stall_cnt got %0d want 2", stall_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL raw_drained got %0b want 0", out_valid); end
    drive_cycle(1'b1, 8'hB2, 3'd3, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 3'd3, 64'h1234);
    if (BYPASS) begin
      n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL raw_wb_ready got %0b want 1", obs_ready); end
    end else begin
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL raw_wb_ready got %0b want 0", obs_ready); end
      drive_cycle(1'b1, 8'hB2, 3'd3, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, '0, '0);
      n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL raw_post_wb_ready got %0b want 1", obs_ready); end
    end
    n_cmp++; if (out_valid !== 1'b1 || out_a !== 64'h1234) begin n_bad++;
      $display("FAIL raw_result got v=%0b a=%h want 1/1234", out_valid, out_a); end
    n_cmp++; if (stall_cnt !== (BYPASS ? 32'd2 : 32'd3)) begin n_bad++;
      $display("FAIL raw_final_cnt got %0d want %0d", stall_cnt, BYPASS ? 2 : 3); end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 8'hC3, 3'd1, 3'd2, 3'd6, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 8'hD4, 3'd2, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0, '0, '0);
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready cyc%0d got %0b want 0", i, obs_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_op !== 8'hC3 || out_a !== 64'd5 || out_b !== 64'd7 || out_rd !== 3'd6) begin
        n_bad++; $display("FAIL bp_hold cyc%0d got v=%0b op=%h a=%0d b=%0d rd=%0d want 1/c3/5/7/6",
                          i, out_valid, out_op, out_a, out_b, out_rd); end
    end
    drive_cycle(1'b1, 8'hD4, 3'd2, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0b want 1", obs_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_op !== 8'hD4 || out_a !== 64'd7 || out_b !== 64'd5) begin n_bad++;
      $display("FAIL bp_release_data got v=%0b op=%h a=%0d b=%0d want 1/d4/7/5", out_valid, out_op, out_a, out_b); end
    n_cmp++; if (stall_cnt !== m_stall) begin n_bad++; $display("FAIL bp_no_stall_count got %0d want %0d", stall_cnt, m_stall); end
  endtask

  task automatic test_set_wins();
    drive_cycle(1'b1, 8'hE5, 3'd0, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd4, 64'h44);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL setwin_issue_ready got %0b want 1", obs_ready); end
    drive_cycle(1'b1, 8'hF6, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL setwin_consumer_stall got %0b want 0", obs_ready); end
    drive_cycle(1'b1, 8'hF6, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd4, 64'h4444);
    if (!BYPASS) drive_cycle(1'b1, 8'hF6, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1 || out_a !== 64'h4444) begin n_bad++;
      $display("FAIL setwin_consumer_issue got rdy=%0b a=%h want 1/4444", obs_ready, out_a); end
  endtask

  task automatic test_reset_full();
    drive_cycle(1'b1, 8'h11, 3'd0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstfull_setup got %0b want 1", out_valid); end
    do_reset(1);
    n_cmp++; if (out_valid !== 1'b0 || out_a !== '0 || stall_cnt !== '0) begin n_bad++;
      $display("FAIL rstfull_cleared got v=%0b a=%h cnt=%0d want 0/0/0", out_valid, out_a, stall_cnt); end
    drive_cycle(1'b1, 8'h22, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1 || stall_cnt !== '0) begin n_bad++;
      $display("FAIL rstfull_no_stall got rdy=%0b cnt=%0d want 1/0", obs_ready, stall_cnt); end
    n_cmp++; if (out_a !== rf_mem[3] || out_rd !== 3'd3) begin n_bad++;
      $display("FAIL rstfull_issue got a=%h rd=%0d want %h/3", out_a, out_rd, rf_mem[3]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bit v, wen, ordy, wbv;
      logic [AW-1:0] rs0, rs1, rd, wba;
      logic [OPW-1:0] op;
      logic [DW-1:0] wbd;
      v    = ($urandom_range(0, 3) != 0);
      wen  = $urandom_range(0, 1) != 0;
      ordy = ($urandom_range(0, 3) != 0);
      wbv  = $urandom_range(0, 1) != 0;
      rs0  = AW'($urandom_range(0, 7));
      rs1  = AW'($urandom_range(0, 7));
      rd   = AW'($urandom_range(0, 7));
      op   = OPW'($urandom);
      wbd  = {$urandom, $urandom};
      wba  = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) begin
        for (int k = 0; k < NREG; k++) begin
          if (m_pend[(int'(wba) + k) % NREG]) begin
            wba = AW'((int'(wba) + k) % NREG);
            break;
          end
        end
      end
      drive_cycle(v, op, rs0, rs1, rd, wen, ordy, wbv, wba, wbd);
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc%0d got %0b want %0b", c, obs_ready, exp_ready); end
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", c, out_valid, m_valid); end
      n_cmp++; if (out_a !== m_a || out_b !== m_b) begin n_bad++;
        $display("FAIL rnd_operands cyc%0d got %h/%h want %h/%h", c, out_a, out_b, m_a, m_b); end
      n_cmp++; if (out_op !== m_op || out_rd !== m_rd || out_wen !== m_wen) begin n_bad++;
        $display("FAIL rnd_ctrl cyc%0d got %h/%0d/%0b want %h/%0d/%0b", c, out_op, out_rd, out_wen, m_op, m_rd, m_wen); end
      n_cmp++; if (stall_cnt !== m_stall) begin n_bad++; $display("FAIL rnd_stall cyc%0d got %0d want %0d", c, stall_cnt, m_stall); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs0 = '0; in_rs1 = '0; in_rd = '0;
    in_wen = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    test_reset();
    test_issue();
    test_raw_stall();
    test_backpressure();
    test_set_wins();
    test_reset_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
